// File: rtl/imem_loader_if.sv
// +----------------------------------------------------------------------------+
// | imem_loader_if : host-side byte stream and imem write-port bundle.          |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

interface imem_loader_if #(
  parameter int CNT_W = 8
) ();
  logic             start;
  logic [CNT_W-1:0] word_count;
  logic [7:0]       byte_in;
  logic             byte_valid;
  logic             byte_ready;
  logic             wr_en;
  logic [31:0]      wr_addr;
  logic [31:0]      wr_data;
  logic             busy;
  logic             done;
  logic             error;

  modport master (
    output start, word_count, byte_in, byte_valid,
    input  byte_ready, wr_en, wr_addr, wr_data, busy, done, error
  );

  modport slave (
    input  start, word_count, byte_in, byte_valid,
    output byte_ready, wr_en, wr_addr, wr_data, busy, done, error
  );
endinterface

`default_nettype wire

// File: rtl/imem_loader.sv
// +----------------------------------------------------------------------------+
// | imem_loader : assembles big-endian bytes into words and writes them to the  |
// | instruction memory. Optional trailing checksum: IMEM_LOADER_CHECKSUM_EN.    |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module imem_loader #(
  parameter int          DEPTH     = 128,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          CNT_W     = 8
) (
  input  wire logic      clk,
  input  wire logic      rst_n,
  imem_loader_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_WRITE = 3'd2,
`ifdef IMEM_LOADER_CHECKSUM_EN
    S_CHECK = 3'd4,
`endif
    S_DONE  = 3'd3
  } state_t;

  localparam logic [CNT_W-1:0] c_depth = CNT_W'(DEPTH);

  state_t           r_state;
  state_t           w_state_next;
  logic [1:0]       r_byte_cnt;
  logic [CNT_W-1:0] r_word_cnt;
  logic [CNT_W-1:0] r_count;
  logic [31:0]      r_wr_addr;
  logic [31:0]      r_wr_data;
  logic             r_error;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]       r_sum;
  logic             w_chk_accept;
`endif

  logic w_start_ok;
  logic w_bad_cnt;
  logic w_zero_cnt;
  logic w_accept;
  logic w_last_word;
  logic w_byte_ready;
  logic w_wr_en;
  logic w_busy;
  logic w_done;

  assign w_start_ok  = bus.start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_bad_cnt   = bus.word_count > c_depth;
  assign w_zero_cnt  = (bus.word_count == '0);
  assign w_accept    = (r_state == S_LOAD) && bus.byte_valid;
  assign w_last_word = ((r_word_cnt + CNT_W'(1)) == r_count);
`ifdef IMEM_LOADER_CHECKSUM_EN
  assign w_chk_accept = (r_state == S_CHECK) && bus.byte_valid;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_byte_ready = 1'b0;
    w_wr_en      = 1'b0;
    w_busy       = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        w_done = (r_state == S_DONE);
        if (w_start_ok) begin
          if (w_bad_cnt) begin
            w_state_next = S_DONE;
          end else if (w_zero_cnt) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            w_state_next = S_CHECK;
`else
            w_state_next = S_DONE;
`endif
          end else begin
            w_state_next = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        w_byte_ready = 1'b1;
        w_busy       = 1'b1;
        if (w_accept && (r_byte_cnt == 2'd3)) begin
          w_state_next = S_WRITE;
        end
      end
      S_WRITE: begin
        w_wr_en = 1'b1;
        w_busy  = 1'b1;
        if (w_last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          w_state_next = S_CHECK;
`else
          w_state_next = S_DONE;
`endif
        end else begin
          w_state_next = S_LOAD;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHECK: begin
        w_byte_ready = 1'b1;
        w_busy       = 1'b1;
        if (bus.byte_valid) begin
          w_state_next = S_DONE;
        end
      end
`endif
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Datapath: word assembly, address/word counters and the error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_byte_cnt <= 2'd0;
      r_word_cnt <= '0;
      r_count    <= '0;
      r_wr_addr  <= BASE_ADDR;
      r_wr_data  <= 32'h0;
      r_error    <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      r_sum      <= 8'h00;
`endif
    end else begin
      if (w_start_ok) begin
        r_byte_cnt <= 2'd0;
        r_word_cnt <= '0;
        r_count    <= bus.word_count;
        r_wr_addr  <= BASE_ADDR;
        r_error    <= w_bad_cnt;
`ifdef IMEM_LOADER_CHECKSUM_EN
        r_sum      <= 8'h00;
`endif
      end
      if (w_accept) begin
        case (r_byte_cnt)
          2'd0:    r_wr_data[31:24] <= bus.byte_in;
          2'd1:    r_wr_data[23:16] <= bus.byte_in;
          2'd2:    r_wr_data[15:8]  <= bus.byte_in;
          default: r_wr_data[7:0]   <= bus.byte_in;
        endcase
        r_byte_cnt <= r_byte_cnt + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
        r_sum      <= r_sum + bus.byte_in;
`endif
      end
      if (r_state == S_WRITE) begin
        r_wr_addr  <= r_wr_addr + 32'd4;
        r_word_cnt <= r_word_cnt + CNT_W'(1);
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      if (w_chk_accept) begin
        r_error <= (bus.byte_in != r_sum);
      end
`endif
    end
  end

  assign bus.byte_ready = w_byte_ready;
  assign bus.wr_en      = w_wr_en;
  assign bus.wr_addr    = r_wr_addr;
  assign bus.wr_data    = r_wr_data;
  assign bus.busy       = w_busy;
  assign bus.done       = w_done;
  assign bus.error      = r_error;

endmodule

`default_nettype wire
